hist_reader: RTL and testbench

HIST_READER -- requirements
Module: hist_reader

---
 rtl/huffman_pkg.sv | 17 +
 rtl/hist_reader.sv | 130 +++++++++++++
 tb/tb_hist_reader.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/huffman_pkg.sv
// Shared Huffman front-end types: histogram geometry, bin array type and
// the reader FSM state encoding used by the byte counter and hist_reader.
package huffman_pkg;

  localparam int NUM_SYM = 128;
  localparam int CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_OUT  = 2'd2,
    ST_DONE = 2'd3
  } hist_state_e;

  typedef logic [NUM_SYM-1:0][CNT_W-1:0] hist_t;

endpackage

// File: rtl/hist_reader.sv
// Walks a stable histogram one bin per cycle and streams non-zero bins out
// over a valid/ready handshake. HIST_READER_TOTAL_EN adds the total_cnt sum.
//
// state | meaning
// IDLE  | waiting for a finish_cnt rising edge
// SCAN  | examining curr_count[idx]
// OUT   | presenting (idx, count) until sym_ready
// DONE  | scan finished, hold results while finish_cnt stays high
module hist_reader
  import huffman_pkg::*;
#(
  parameter int NUM_SYM = huffman_pkg::NUM_SYM,
  parameter int CNT_W   = huffman_pkg::CNT_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_SYM-1:0][CNT_W-1:0] curr_count,
  input  logic                          finish_cnt,
  input  logic                          sym_ready,
  output logic                          sym_valid,
  output logic [6:0]                    sym_char,
  output logic [CNT_W-1:0]              sym_freq,
  output logic [7:0]                    num_syms,
  output logic                          scan_done
`ifdef HIST_READER_TOTAL_EN
  ,
  output logic [CNT_W+6:0]              total_cnt
`endif
);

  localparam logic [6:0] LAST_IDX = 7'(NUM_SYM - 1);

  hist_state_e       r_state;
  hist_state_e       w_next;
  logic [6:0]        r_idx;
  logic [6:0]        r_sym_char;
  logic [CNT_W-1:0]  r_sym_freq;
  logic [7:0]        r_num_syms;
  logic              r_fin_q;
  logic              r_fin_armed;

  logic [CNT_W-1:0]  w_bin;
  logic              w_bin_nz;
  logic              w_last;
  logic              w_fin_rise;
  logic              w_start;
  logic              w_load;
  logic              w_adv;
  logic              w_hs;

  assign w_bin    = curr_count[r_idx];
  assign w_bin_nz = (w_bin != '0);
  assign w_last   = (r_idx == LAST_IDX);
  // A level already high out of reset must fall once before it can count as a rise.
  assign w_fin_rise = finish_cnt & ~r_fin_q & r_fin_armed;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (w_fin_rise) w_next = ST_SCAN;
      ST_SCAN: begin
        if (!finish_cnt)   w_next = ST_IDLE;
        else if (w_bin_nz) w_next = ST_OUT;
        else if (w_last)   w_next = ST_DONE;
      end
      ST_OUT: begin
        if (!finish_cnt)    w_next = ST_IDLE;
        else if (sym_ready) w_next = w_last ? ST_DONE : ST_SCAN;
      end
      ST_DONE: if (!finish_cnt) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    sym_valid = (r_state == ST_OUT);
    scan_done = (r_state == ST_DONE);
    w_start   = (r_state == ST_IDLE) && w_fin_rise;
    w_load    = (r_state == ST_SCAN) && finish_cnt && w_bin_nz;
    w_hs      = (r_state == ST_OUT) && finish_cnt && sym_ready;
    w_adv     = ((r_state == ST_SCAN) && finish_cnt && !w_bin_nz && !w_last) ||
                (w_hs && !w_last);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx       <= '0;
      r_sym_char  <= '0;
      r_sym_freq  <= '0;
      r_num_syms  <= '0;
      r_fin_q     <= 1'b0;
      r_fin_armed <= 1'b0;
    end else begin
      r_fin_q <= finish_cnt;
      if (!finish_cnt) r_fin_armed <= 1'b1;
      if (w_start) begin
        r_idx      <= '0;
        r_num_syms <= '0;
      end
      if (w_load) begin
        r_sym_char <= r_idx;
        r_sym_freq <= w_bin;
      end
      if (w_adv) r_idx <= r_idx + 7'd1;
      if (w_hs)  r_num_syms <= r_num_syms + 8'd1;
    end
  end

  assign sym_char = r_sym_char;
  assign sym_freq = r_sym_freq;
  assign num_syms = r_num_syms;

`ifdef HIST_READER_TOTAL_EN
  logic [CNT_W+6:0] r_total;

  always_ff @(posedge clk) begin
    if (!reset)       r_total <= '0;
    else if (w_start) r_total <= '0;
    else if (w_hs)    r_total <= r_total + {7'd0, r_sym_freq};
  end

  assign total_cnt = r_total;
`endif

endmodule

// File: tb/tb_hist_reader.sv
// Directed + randomized bench for hist_reader; expected entry stream comes
// from a plain list of non-zero bins. Build with HIST_READER_TOTAL_EN to check total_cnt.
module tb_hist_reader;

  localparam int NS = 128;
  localparam int CW = 16;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   finish_cnt = 1'b0;
  logic                   sym_ready = 1'b0;
  logic [NS-1:0][CW-1:0]  hist = '0;
  logic                   sym_valid;
  logic [6:0]             sym_char;
  logic [CW-1:0]          sym_freq;
  logic [7:0]             num_syms;
  logic                   scan_done;
`ifdef HIST_READER_TOTAL_EN
  logic [CW+6:0]          total_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  hist_reader #(.NUM_SYM(NS), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .curr_count (hist),
    .finish_cnt (finish_cnt),
    .sym_ready  (sym_ready),
    .sym_valid  (sym_valid),
    .sym_char   (sym_char),
    .sym_freq   (sym_freq),
    .num_syms   (num_syms),
    .scan_done  (scan_done)
`ifdef HIST_READER_TOTAL_EN
    ,
    .total_cnt  (total_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // mode 0: ready always high; 1: random ready; 2: ready low for 3 cycles per entry
  task automatic run_scan(input string name, input int mode, output int last_char);
    int     q_char[$];
    int     q_freq[$];
    int     n_exp;
    int     cycles;
    int     vcyc;
    int     waitc;
    int     num;
    longint sum;
    logic   v_prev;
    logic   r;
    q_char.delete();
    q_freq.delete();
    for (int i = 0; i < NS; i++) begin
      if (hist[i] != '0) begin
        q_char.push_back(i);
        q_freq.push_back(int'(hist[i]));
      end
    end
    n_exp = q_char.size();
    last_char = -1;
    finish_cnt = 1'b0;
    sym_ready  = 1'b0;
    step();
    finish_cnt = 1'b1;
    step();
    chk({name, ".start_num"},   32'(num_syms),  32'd0);
    chk({name, ".start_valid"}, 32'(sym_valid), 32'd0);
    cycles = 0; vcyc = 0; waitc = 0; num = 0; sum = 0;
    while (!scan_done && cycles < 2000) begin
      v_prev = sym_valid;
      if (sym_valid) begin
        vcyc++;
        chk({name, ".has_entry"}, 32'(q_char.size() > 0), 32'd1);
        if (q_char.size() > 0) begin
          chk({name, ".char"}, 32'(sym_char), 32'(q_char[0]));
          chk({name, ".freq"}, 32'(sym_freq), 32'(q_freq[0]));
        end
        case (mode)
          0:       r = 1'b1;
          2:       r = (waitc >= 3);
          default: r = 1'($urandom_range(0, 1));
        endcase
        waitc++;
      end else begin
        r = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
      sym_ready = r;
      step();
      cycles++;
      if (v_prev && r && q_char.size() > 0) begin
        last_char = q_char.pop_front();
        sum += longint'(q_freq.pop_front());
        num++;
        waitc = 0;
      end
      chk({name, ".num_syms"}, 32'(num_syms), 32'(num));
    end
    chk({name, ".done"},      32'(scan_done),     32'd1);
    chk({name, ".cycles"},    32'(cycles),        32'(NS + vcyc));
    chk({name, ".remaining"}, 32'(q_char.size()), 32'd0);
    chk({name, ".count"},     32'(num_syms),      32'(n_exp));
    if (mode == 2) chk({name, ".valid_cycles"}, 32'(vcyc), 32'(4 * n_exp));
`ifdef HIST_READER_TOTAL_EN
    chk({name, ".total"}, 32'(total_cnt), 32'(sum));
`endif
    sym_ready = 1'b1;
    step();
    step();
    chk({name, ".hold_done"},  32'(scan_done), 32'd1);
    chk({name, ".hold_num"},   32'(num_syms),  32'(n_exp));
    chk({name, ".hold_valid"}, 32'(sym_valid), 32'd0);
    sym_ready = 1'b0;
  endtask

  task automatic start_and_wait_valid(input string name);
    int guard;
    finish_cnt = 1'b0;
    sym_ready  = 1'b0;
    step();
    finish_cnt = 1'b1;
    step();
    guard = 0;
    while (!sym_valid && guard < 200) begin
      step();
      guard++;
    end
    chk({name, ".reached_out"}, 32'(sym_valid), 32'd1);
  endtask

  initial begin
    int last;
    // Reset held with finish_cnt high, histogram non-empty
    reset = 1'b0;
    finish_cnt = 1'b1;
    hist = '0;
    hist[0] = 16'd9;
    step();
    step();
    chk("rst.valid", 32'(sym_valid), 32'd0);
    chk("rst.char",  32'(sym_char),  32'd0);
    chk("rst.freq",  32'(sym_freq),  32'd0);
    chk("rst.num",   32'(num_syms),  32'd0);
    chk("rst.done",  32'(scan_done), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("rst.no_start_valid", 32'(sym_valid), 32'd0);
      chk("rst.no_start_done",  32'(scan_done), 32'd0);
    end

    // Sparse histogram
    hist = '0;
    hist[0] = 16'd1; hist[3] = 16'd1; hist[12] = 16'd1; hist[20] = 16'd1;
    run_scan("sparse", 0, last);
    chk("sparse.last", 32'(last), 32'd20);

    // Backpressure on a single bin
    hist = '0;
    hist[5] = 16'd7;
    run_scan("bp", 2, last);
    chk("bp.last", 32'(last), 32'd5);

    // Empty histogram
    hist = '0;
    run_scan("empty", 1, last);

    // Extremes at both ends of the index range
    hist = '0;
    hist[0] = 16'hFFFF;
    hist[127] = 16'd2;
    run_scan("bound", 0, last);
    chk("bound.last", 32'(last), 32'd127);
`ifdef HIST_READER_TOTAL_EN
    chk("bound.total_const", 32'(total_cnt), 32'd65537);
`endif

    // Abort while presenting bin 3, then restart from idx 0
    hist = '0;
    hist[3] = 16'd5;
    start_and_wait_valid("abort");
    chk("abort.char", 32'(sym_char), 32'd3);
    finish_cnt = 1'b0;
    step();
    chk("abort.valid", 32'(sym_valid), 32'd0);
    chk("abort.num",   32'(num_syms),  32'd0);
    chk("abort.done",  32'(scan_done), 32'd0);
    step();
    chk("abort.idle_valid", 32'(sym_valid), 32'd0);
    hist[0] = 16'd4;
    run_scan("restart", 0, last);
    chk("restart.last", 32'(last), 32'd3);

    // Reset in the middle of a handshake
    hist = '0;
    hist[40] = 16'd11;
    hist[90] = 16'd3;
    start_and_wait_valid("midrst");
    reset = 1'b0;
    sym_ready = 1'b1;
    step();
    chk("midrst.valid", 32'(sym_valid), 32'd0);
    chk("midrst.num",   32'(num_syms),  32'd0);
    chk("midrst.char",  32'(sym_char),  32'd0);
    chk("midrst.freq",  32'(sym_freq),  32'd0);
    reset = 1'b1;
    sym_ready = 1'b0;
    step();
    step();
    chk("midrst.no_restart", 32'(sym_valid), 32'd0);

    // Randomized histograms with random backpressure
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < NS; i++)
        hist[i] = ($urandom_range(0, 9) < 2) ? CW'($urandom_range(1, 65535)) : '0;
      run_scan("rand", 1, last);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
